div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider that answers divide requests from the execute stage. The execute stage raises a start request and stalls the pipeline. This block latches the operands, runs a radix-2 restoring division over 32 cycles, and returns quotient and remainder with a ready flag. The result is then forwarded toward the HI/LO write path through ex_mem.

## Interface
- No parameters; widths come from the shared defines (`RegBus` = 32 bits, `DoubleRegBus` = 64 bits).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; state is cleared while rst = 0.
- signed_div_i  in  1  1 = signed division (div), 0 = unsigned (divu).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request, held high by the execute stage until ready_o is seen.
- annul_i  in  1  abort the operation in flight (flush/exception).
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result_o valid.

## Operation
- States are FREE, BYZERO, ON and END. Encodings are in the shared defines.
- **FREE**
  - start_i = 1 and annul_i = 0, divisor = 0: go to BYZERO.
  - start_i = 1 and annul_i = 0, divisor ≠ 0: go to ON. Latch operands (absolute values when signed), latch both operand signs, clear the iteration count.
  - start_i = 1 and annul_i = 1: stay in FREE; no launch.
- **BYZERO**
  - Go to END with result = 0.
  - annul_i = 1: go to FREE instead.
- **ON**
  - Each cycle: shift the 65-bit working register {partial remainder, dividend} left by 1, trial-subtract the divisor, set the quotient bit, and increment the count.
  - After iteration 32, go to END.
  - annul_i = 1 on any edge: go to FREE immediately and discard the partial result.
- **END**
  - ready_o = 1 and result_o is valid; both are held until start_i = 0 is sampled, then go to FREE.
  - annul_i is ignored in END.
- **Signed correction** (applied on entry to END):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- **Overflow:** 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. No trap.
- Operand changes after the launch edge have no effect.

## Timing
- **Reset** (rst = 0, asynchronous):
  - state = FREE, count = 0, result_o = 0, ready_o = 0.
  - A divide in flight is lost and no ready_o is produced.
- ready_o and result_o are registered outputs.
- **Normal division:**
  - Launch edge E0; iterations on E1..E32.
  - ready_o is high in the cycle after E32, i.e. 33 cycles after start_i is first sampled.
- **Divide-by-zero:** ready_o is high in the cycle after E1, i.e. 2 cycles after start_i is first sampled.
- **Back-to-back divides:** start_i must drop for at least one sampled edge between them.
- **ready_o falling edge:** ready_o drops the cycle after start_i = 0 is sampled in END.

## Configuration
- `DIV_SIGNED_EN` defined:
  - signed_div_i is honoured.
  - Operand absolute values are taken, and the signed correction in Operation is applied.
- `DIV_SIGNED_EN` undefined:
  - signed_div_i is ignored and every division is unsigned.
  - Sign-handling logic is removed.

## Structure
- **Shared defines header:**
  - State encodings DivFree, DivByZero, DivOn, DivEnd.
  - DivStart/DivStop and DivResultReady/DivResultNotReady.
  - `ZeroWord`, `RegBus`, `DoubleRegBus`.
- **Sub-module:** one combinational sub-module, div_step.
  - Inputs: 65-bit working register and divisor.
  - Output: next working register.
  - Instantiated once and reused each cycle.

## Test plan
- **Unsigned divide:** unsigned 100 / 7 -> at E0+33: result_o = {0x00000002, 0x0000000E}, ready_o = 1.
- **Signed divide, negative dividend:** signed −7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - With `DIV_SIGNED_EN` undefined: quotient 0x7FFFFFFC, remainder 0x00000001.
- **Signed overflow:** signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- **Divide by zero:** 5 / 0 -> ready_o = 1 two cycles after start_i, result_o = 0; ready_o drops one cycle after start_i falls.
- **Annul:** annul_i pulsed at iteration 10 -> state FREE next edge, ready_o stays 0; a new divide 9 / 3 then completes with quotient 3, remainder 0.
- **Reset mid-operation:** rst low at iteration 20 -> outputs 0 immediately, no ready_o; after release, 1 / 1 gives quotient 1, remainder 0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared defines for the multi-cycle divider.
//   - FSM state encodings (DivFree, DivByZero, DivOn, DivEnd)
//   - start / result-ready flag values
//   - bus widths (RegBus, DoubleRegBus) and ZeroWord
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Number of restoring iterations, one quotient bit each.
  localparam logic [5:0] DivIters = 6'd32;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration (combinational).
//   work      in  65  {partial remainder[64:32], dividend bits[31:0]}
//   divisor   in  32  divisor (magnitude)
//   work_next out 65  working register after shift / trial subtract
// The low 32 bits gradually turn from dividend bits into quotient bits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [64:0]       work,
  input  logic [RegBus-1:0] divisor,
  output logic [64:0]       work_next
);

  logic [64:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {work[63:0], 1'b0};
    // 34-bit subtract so the top bit is a clean borrow flag.
    diff    = {1'b0, shifted[64:32]} - {2'b00, divisor};
    if (diff[33]) begin
      // Trial subtract went negative: restore, quotient bit 0.
      work_next = shifted;
    end else begin
      work_next = {diff[32:0], shifted[31:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit divider (radix-2 restoring, 32 iterations).
// Optional feature macro: DIV_SIGNED_EN (signed division support).
//   clk           in   1  clock, rising edge
//   rst           in   1  asynchronous reset, active low
//   signed_div_i  in   1  1 = signed (div), 0 = unsigned (divu)
//   opdata1_i     in  32  dividend
//   opdata2_i     in  32  divisor
//   start_i       in   1  request, held until ready_o is seen
//   annul_i       in   1  abort the operation in flight
//   result_o      out 64  {remainder, quotient}
//   ready_o       out  1  result_o valid
//   dbg_state     out  2  current FSM state (debug visibility)
// Handshake: start_i is a level request held high until ready_o is seen;
// ready_o/result_o are held in END until start_i = 0 is sampled, so a new
// divide requires start_i to be low for at least one sampled edge.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic [1:0]              dbg_state
);

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic [64:0]       work;
  logic [64:0]       work_next;
  logic [RegBus-1:0] divisor;
  logic [RegBus-1:0] op1_abs;
  logic [RegBus-1:0] op2_abs;
  logic [RegBus-1:0] quot_fix;
  logic [RegBus-1:0] rem_fix;

  div_step u_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_next)
  );

`ifdef DIV_SIGNED_EN
  logic neg_quot;
  logic neg_rem;
  logic is_signed;

  assign is_signed = signed_div_i;

  always_comb begin
    op1_abs = (is_signed && opdata1_i[31]) ? (ZeroWord - opdata1_i) : opdata1_i;
    op2_abs = (is_signed && opdata2_i[31]) ? (ZeroWord - opdata2_i) : opdata2_i;
    // Quotient negative when signs differ; remainder follows the dividend.
    quot_fix = neg_quot ? (ZeroWord - work_next[31:0])  : work_next[31:0];
    rem_fix  = neg_rem  ? (ZeroWord - work_next[63:32]) : work_next[63:32];
  end

  // Signs captured at launch so later operand changes have no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (state == DivFree && start_i == DivStart && !annul_i) begin
      neg_quot <= is_signed && (opdata1_i[31] ^ opdata2_i[31]);
      neg_rem  <= is_signed && opdata1_i[31];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = signed_div_i;

  always_comb begin
    op1_abs  = opdata1_i;
    op2_abs  = opdata2_i;
    quot_fix = work_next[31:0];
    rem_fix  = work_next[63:32];
  end
`endif

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= 6'd0;
      work     <= '0;
      divisor  <= ZeroWord;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == ZeroWord) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              work    <= {33'd0, op1_abs};
              divisor <= op2_abs;
              cnt     <= 6'd0;
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            state    <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
            cnt   <= 6'd0;
          end else begin
            work <= work_next;
            cnt  <= cnt + 6'd1;
            // This edge performs the final iteration; publish the result.
            if (cnt == DivIters - 6'd1) begin
              state    <= DivEnd;
              result_o <= {rem_fix, quot_fix};
              ready_o  <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
            cnt      <= 6'd0;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed testbench for div_unit.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;
  int ready_seen;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .dbg_state    (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Full divide: ready must be low after E31 and high after E32 (33 edges
  // from launch), result held while start stays high, drop after release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();  // E0 launch
    // Operands may wander after launch without affecting the result.
    opdata1_i = $urandom();
    opdata2_i = $urandom();
    signed_div_i = $urandom_range(0, 1);
    repeat (31) tick();  // E1..E31
    check({tag, "_early"}, {63'd0, ready_o}, 64'd0);
    tick();              // E32
    check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_result"}, result_o, {exp_r, exp_q});
    tick();              // held while start high
    check({tag, "_hold"}, {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    tick();
    check({tag, "_drop"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    // Reset state
    #12;
    check("rst_ready", {63'd0, ready_o}, 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, DivFree});
    rst = 1'b1;
    tick();

    // Unsigned divides
    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
    run_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'h0000_000F);

    // Signed divides and overflow
`ifdef DIV_SIGNED_EN
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
`else
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'h0000_0001);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0007);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
`endif

    // Divide by zero: ready two edges after launch
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    tick();  // E0
    check("dz_early", {63'd0, ready_o}, 64'd0);
    check("dz_state", {62'd0, dbg_state}, {62'd0, DivByZero});
    tick();  // E1
    check("dz_ready", {63'd0, ready_o}, 64'd1);
    check("dz_result", result_o, 64'd0);
    tick();
    check("dz_hold", {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    tick();
    check("dz_drop", {63'd0, ready_o}, 64'd0);

    // Annul at iteration 10
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();              // E0
    repeat (9) tick();   // E1..E9
    annul_i = 1'b1;
    tick();              // E10 aborts
    check("an_state", {62'd0, dbg_state}, {62'd0, DivFree});
    check("an_ready", {63'd0, ready_o}, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    ready_seen = 0;
    repeat (40) begin
      tick();
      if (ready_o) ready_seen++;
    end
    check("an_no_ready", 64'(ready_seen), 64'd0);
    run_div("an_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // Reset mid-operation at iteration 20
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    tick();              // E0
    repeat (19) tick();  // E1..E19
    rst = 1'b0;
    #1;
    check("mr_ready", {63'd0, ready_o}, 64'd0);
    check("mr_result", result_o, 64'd0);
    check("mr_state", {62'd0, dbg_state}, {62'd0, DivFree});
    start_i = 1'b0;
    ready_seen = 0;
    repeat (20) begin
      tick();
      if (ready_o) ready_seen++;
    end
    check("mr_no_ready", 64'(ready_seen), 64'd0);
    rst = 1'b1;
    tick();
    run_div("mr_1_1", 1'b0, 32'd1, 32'd1, 32'd1, 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
